// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default link constants
// and a parity helper. The transmit side uses the same constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLK_HZ     = 50_000_000;
  localparam int DEFAULT_BAUD       = 115_200;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_TICK_DIV   = DEFAULT_CLK_HZ / (DEFAULT_BAUD * DEFAULT_OVERSAMPLE);

  // Error when data XOR parity sample disagrees with the selected polarity.
  function automatic logic parity_mismatch(input logic data_xor, input logic sample,
                                           input logic odd);
    return (data_xor ^ sample) != odd;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 so an
// idle-high line never looks active while reset is being released.
module bit_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled deserialiser with framing/parity/overrun
// reporting and a valid/ready output handshake. All state advances on tick_en.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_M1 = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_M1 = 4'(STOP_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 guard_q, guard_d;
  logic                 done_s;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q, busy_q;

  bit_sync u_rx_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    guard_d = guard_q;
    done_s  = 1'b0;
    if (tick_en) begin
      case (state_q)
        IDLE: begin
          // After a framing error the line may sit in break; wait for it to go high.
          if (guard_q) begin
            guard_d = ~rx_s;
          end else if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bit_d   = 4'd0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_M1) begin
              bit_d   = 4'd0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            perr_d  = parity_mismatch(^shift_q, rx_s, (PARITY_ODD != 0));
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            ferr_d = ferr_q | ~rx_s;
            if (bit_q == STOP_M1) begin
              bit_d   = 4'd0;
              state_d = IDLE;
              done_s  = 1'b1;
              guard_d = ferr_q | ~rx_s;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          bit_d   = 4'd0;
        end
      endcase
    end else begin
      done_s = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= 4'd0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      guard_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      guard_q <= guard_d;
      busy_q  <= (state_d != IDLE);
      // A pending unaccepted word wins over a new one; the new one is counted as overrun.
      if (done_s) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          frame_err_q  <= ferr_d;
          parity_err_q <= perr_d;
          rx_valid_q   <= 1'b1;
          overrun_q    <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end else begin
        rx_valid_q <= rx_valid_q;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, each fed
// its own serial line, with a tick every 4 clocks (one bit = 64 clocks).
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic       clk, reset, tick_en;
  logic       rx_a, rx_b, ready_a;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_a = 0, frames_b = 0, vcyc_a = 0;
  logic prev_va = 1'b0, prev_vb = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clock(clk), .reset(reset), .tick_en(tick_en), .rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clock(clk), .reset(reset), .tick_en(tick_en), .rx(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(1'b1),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_en = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick_en = 1'b1;
      @(negedge clk);
      tick_en = 1'b0;
    end
  end

  // Count delivered words (rising edges of rx_valid) and valid-high cycles.
  always @(negedge clk) begin
    if (valid_a) vcyc_a++;
    if (valid_a && !prev_va) frames_a++;
    if (valid_b && !prev_vb) frames_b++;
    prev_va = valid_a;
    prev_vb = valid_b;
  end

  task automatic drive(input bit sel, input logic b, input int nclk);
    if (sel) rx_b = b; else rx_a = b;
    repeat (nclk) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level; the caller returns it to idle.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop);
    drive(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLKS);
    if (par_en) drive(sel, par, BIT_CLKS);
    drive(sel, stop, BIT_CLKS);
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_a); end
    n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_a); end
    n_checks++; if ({fe_a, pe_a, ovr_a, busy_a} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {fe_a, pe_a, ovr_a, busy_a}); end
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_basic;
    int f0, v0;
    f0 = frames_a; v0 = vcyc_a;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if (frames_a !== f0 + 1) begin n_fail++; $display("FAIL basic_frames got %0d want %0d", frames_a, f0 + 1); end
    n_checks++; if (vcyc_a !== v0 + 1) begin n_fail++; $display("FAIL basic_valid_cycles got %0d want %0d", vcyc_a, v0 + 1); end
    n_checks++; if (data_a !== 8'h55) begin n_fail++; $display("FAIL basic_data got %h want 55", data_a); end
    n_checks++; if ({fe_a, pe_a, ovr_a, busy_a} !== 4'b0000) begin n_fail++; $display("FAIL basic_flags got %b want 0000", {fe_a, pe_a, ovr_a, busy_a}); end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = frames_a;
    drive(1'b0, 1'b0, 12);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL glitch_busy got %b want 1", busy_a); end
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_idle got %b want 0", busy_a); end
    n_checks++; if (frames_a !== f0) begin n_fail++; $display("FAIL glitch_no_word got %0d want %0d", frames_a, f0); end
    n_checks++; if ({fe_a, pe_a} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags got %b want 00", {fe_a, pe_a}); end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if (frames_a !== f0 + 1) begin n_fail++; $display("FAIL glitch_next_frames got %0d want %0d", frames_a, f0 + 1); end
    n_checks++; if (data_a !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data got %h want 3c", data_a); end
  endtask

  task automatic test_frame_err;
    int f0;
    f0 = frames_a;
    send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (data_a !== 8'hF0) begin n_fail++; $display("FAIL ferr_data got %h want f0", data_a); end
    n_checks++; if ({fe_a, pe_a} !== 2'b10) begin n_fail++; $display("FAIL ferr_flags got %b want 10", {fe_a, pe_a}); end
    drive(1'b0, 1'b0, 2 * BIT_CLKS);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ferr_guard_busy got %b want 0", busy_a); end
    n_checks++; if (frames_a !== f0 + 1) begin n_fail++; $display("FAIL ferr_guard_frames got %0d want %0d", frames_a, f0 + 1); end
    drive(1'b0, 1'b1, 2 * BIT_CLKS);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if (data_a !== 8'hA5) begin n_fail++; $display("FAIL ferr_next_data got %h want a5", data_a); end
    n_checks++; if (fe_a !== 1'b0) begin n_fail++; $display("FAIL ferr_next_fe got %b want 0", fe_a); end
  endtask

  task automatic test_parity;
    int f0;
    f0 = frames_b;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, BIT_CLKS);
    n_checks++; if (data_b !== 8'h07) begin n_fail++; $display("FAIL par_bad_data got %h want 07", data_b); end
    n_checks++; if ({pe_b, fe_b} !== 2'b10) begin n_fail++; $display("FAIL par_bad_flags got %b want 10", {pe_b, fe_b}); end
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, BIT_CLKS);
    n_checks++; if ({pe_b, fe_b} !== 2'b00) begin n_fail++; $display("FAIL par_good_flags got %b want 00", {pe_b, fe_b}); end
    n_checks++; if (frames_b !== f0 + 2) begin n_fail++; $display("FAIL par_frames got %0d want %0d", frames_b, f0 + 2); end
  endtask

  task automatic test_overrun;
    ready_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if ({valid_a, ovr_a} !== 2'b10) begin n_fail++; $display("FAIL ovr_first got %b want 10", {valid_a, ovr_a}); end
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if (data_a !== 8'h11) begin n_fail++; $display("FAIL ovr_keep_data got %h want 11", data_a); end
    n_checks++; if ({valid_a, ovr_a} !== 2'b11) begin n_fail++; $display("FAIL ovr_set got %b want 11", {valid_a, ovr_a}); end
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    n_checks++; if ({valid_a, ovr_a} !== 2'b00) begin n_fail++; $display("FAIL ovr_accept got %b want 00", {valid_a, ovr_a}); end
    repeat (4) @(negedge clk);
    ready_a = 1'b1;
  endtask

  task automatic test_reset_mid;
    int f0;
    f0 = frames_a;
    drive(1'b0, 1'b0, BIT_CLKS);
    drive(1'b0, 1'b0, BIT_CLKS);
    drive(1'b0, 1'b1, BIT_CLKS);
    drive(1'b0, 1'b0, BIT_CLKS / 2);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy_a); end
    reset = 1'b1; rx_a = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h want 00", data_a); end
    n_checks++; if ({valid_a, fe_a, pe_a, ovr_a, busy_a} !== 5'b00000) begin n_fail++; $display("FAIL rmid_flags got %b want 00000", {valid_a, fe_a, pe_a, ovr_a, busy_a}); end
    reset = 1'b0;
    drive(1'b0, 1'b1, 8 * BIT_CLKS);
    n_checks++; if (frames_a !== f0) begin n_fail++; $display("FAIL rmid_no_word got %0d want %0d", frames_a, f0); end
    send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BIT_CLKS);
    n_checks++; if (data_a !== 8'hA3) begin n_fail++; $display("FAIL rmid_next_data got %h want a3", data_a); end
    n_checks++; if (frames_a !== f0 + 1) begin n_fail++; $display("FAIL rmid_next_frames got %0d want %0d", frames_a, f0 + 1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_parity;
    test_overrun;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
